bus_master: RTL and testbench
=============================

Name: bus_master

Overview:
- Parametrised system-bus master sequencer for the CPU. It replaces the fixed single-word request/alarm timing with a command-driven engine.
- Accepts a read/write/in/out command, drives the MERA-400 active-low bus handshake (address setup, strobe, response, full release) and supervises it with an alarm timeout.
- Retries transfers refused with "engaged" and runs multi-word bursts with address increment.
- Sits between the CPU control logic and the open-collector dad_/ddt_/strobe composition at CPU top level.

Parameters:
- AW, 16, address width (bus bit order [0:AW-1]).
- DW, 16, data width.
- LEN_W, 4, burst length field width; length 0 means 2**LEN_W words.
- SETTLE_TICKS, 3, address/data setup cycles before strobe (min 1).
- ALARM_DLY_TICKS, 250, cycles from strobe assertion to alarm if no synchronised response (min 4).
- RETRY_MAX, 3, extra attempts after an ren_ refusal before reporting EN.

Ports:
- __clk  in  1  system clock.
- clm_  in  1  asynchronous active-low reset (master clear).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, command accepted on cmd_valid&cmd_ready.
- cmd_op  in  2  0=read(dr_), 1=write(dw_), 2=in(din_ + dr_-style data return), 3=out(din_ + write data).
- cmd_nb  in  4  segment number driven on dnb_.
- cmd_ad  in  AW  start address.
- cmd_dt  in  DW  write data; sampled per word from wr_dt when burst>1.
- cmd_len  in  LEN_W  word count.
- wr_req  out  1  pulse: next write word needed, sampled from wr_dt next cycle.
- wr_dt  in  DW  burst write data.
- rd_valid  out  1  pulse per successfully read word.
- rd_dt  out  DW  read word (true polarity).
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done: 0=OK, 1=EN (refused), 2=PE (parity), 3=ALARM.
- words  out  LEN_W+1  words completed OK, valid with done.
- dr_, dw_, din_  out  1  active-low strobes.
- dnb_  out  4  active-low segment.
- dad_  out  AW  active-low address.
- ddt_  out  DW  active-low data, driven only for write/out.
- rok_, ren_, rpe_  in  1  active-low slave responses, asynchronous.
- rdt_  in  DW  active-low read data.

Behaviour:
- Reset (clm_ low, async): all bus outputs high (released); cmd_ready=1; rd_valid=done=wr_req=0; status=0; words=0; rd_dt=0; FSM=IDLE; counters cleared. Reset mid-transfer releases the bus immediately, with no completion pulse.
- rok_/ren_/rpe_ pass a 2-flop synchroniser; all decisions use the synchronised versions. rdt_ is captured on the cycle synchronised rok_ is first seen.
- States:
  - IDLE: cmd_ready=1. Accept latches op/nb/ad/dt/len and goes to SETUP.
  - SETUP: dnb_/dad_ (and ddt_ for write/out) driven. Stays SETUP_TICKS cycles, then STROBE.
  - STROBE: strobe low. Alarm counter runs from 0 on entry.
  - STROBE exit, priority rpe > rok > ren > alarm:
    - rpe: result PE.
    - rok: word OK; read/in captures ~rdt_ and pulses rd_valid.
    - ren: refusal.
    - counter == ALARM_DLY_TICKS-1: result ALARM, go straight to DONE (no release wait).
  - RELEASE: strobe high, address/data held. Waits until all synchronised responses are high, then:
    - OK with words remaining: NEXT.
    - OK on the last word: DONE.
    - PE: DONE.
    - ren with retries left: SETUP, same address, retry count +1.
    - ren with retries exhausted: DONE with EN.
  - NEXT: address +1 modulo 2**AW (nb unchanged). For write/out, pulses wr_req; the word is taken from wr_dt in the SETUP entry cycle. Then SETUP. The retry counter resets per word.
  - DONE: done=1 one cycle with status and words, bus released, then IDLE.
- Error in a burst aborts the remaining words; words counts only OK words.
- Latency, single read with no wait: accept at cycle 0; dad_ driven at cycle 1; strobe low at cycle 1+SETUP_TICKS. rok_ low at cycle t gives capture at t+2, RELEASE from t+3. rok_ high at u gives done at u+3.
- A command presented while busy is ignored (cmd_ready=0).

Test Plan:
- Single read: nb=2, ad=16'h0100, slave pulls rok_ with rdt_=~16'h1234 8 cycles after dr_ low -> rd_valid with rd_dt=16'h1234, done, status=0, words=1. dr_ high before done; dad_=~16'h0100 throughout.
- Write burst: len=3 at ad=16'hFFFF, data A/B/C via cmd_dt/wr_dt -> three dw_ strobes at addresses FFFF, 0000, 0001 (wrap). Two wr_req pulses; ddt_ carries ~A, ~B, ~C; status=0, words=3.
- Retry: ren_ asserted on the first 2 attempts, rok_ on the 3rd -> 3 strobes, status=0. With ren_ on every attempt -> RETRY_MAX+1=4 strobes, then status=1, words=0.
- Alarm: no response -> strobe held exactly ALARM_DLY_TICKS cycles, then released; done with status=3. A read burst len=4 alarming on word 2 -> words=1.
- Priority/parity: rpe_ and rok_ asserted in the same cycle -> status=2, no rd_valid.
- Reset mid-STROBE: clm_ low -> all strobes, dad_, ddt_ and dnb_ high asynchronously, with no done. A new command after release runs normally.

Source files
------------

// File: rtl/bus_master.sv
// MERA-400 system-bus master sequencer: runs read/write/in/out command bursts
// over the active-low bus handshake with engaged-retry and alarm timeout.
module bus_master #(
  parameter int AW              = 16,
  parameter int DW              = 16,
  parameter int LEN_W           = 4,
  parameter int SETTLE_TICKS    = 3,
  parameter int ALARM_DLY_TICKS = 250,
  parameter int RETRY_MAX       = 3
) (
  input  logic             __clk,
  input  logic             clm_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_nb,
  input  logic [AW-1:0]    cmd_ad,
  input  logic [DW-1:0]    cmd_dt,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wr_req,
  input  logic [DW-1:0]    wr_dt,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_dt,
  output logic             done,
  output logic [1:0]       status,
  output logic [LEN_W:0]   words,
  output logic             dr_,
  output logic             dw_,
  output logic             din_,
  output logic [3:0]       dnb_,
  output logic [AW-1:0]    dad_,
  output logic [DW-1:0]    ddt_,
  input  logic             rok_,
  input  logic             ren_,
  input  logic             rpe_,
  input  logic [DW-1:0]    rdt_
);

  localparam int CNT_MAX = (ALARM_DLY_TICKS > SETTLE_TICKS) ? ALARM_DLY_TICKS : SETTLE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RT_W    = $clog2(RETRY_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_EN    = 2'd1,
    ST_PE    = 2'd2,
    ST_ALARM = 2'd3
  } status_t;

  state_t         state;
  status_t        result;
  status_t        fin_status;
  logic           fin;
  logic [1:0]     op;
  logic [AW-1:0]  ad;
  logic [LEN_W:0] total;
  logic [LEN_W:0] ok_cnt;
  logic [CNT_W-1:0] cnt;
  logic [RT_W-1:0]  retry;
  logic           load_wr;
  logic [2:0]     resp_s1;
  logic [2:0]     resp_s2;
  logic           rok_s, ren_s, rpe_s, resp_idle;

  // Slave responses are asynchronous; order in the vectors is {rpe_, ren_, rok_}.
  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      resp_s1 <= '1;
      resp_s2 <= '1;
    end else begin
      resp_s1 <= {rpe_, ren_, rok_};
      resp_s2 <= resp_s1;
    end
  end

  assign rok_s     = resp_s2[0];
  assign ren_s     = resp_s2[1];
  assign rpe_s     = resp_s2[2];
  assign resp_idle = &resp_s2;

  // Decides when the transfer ends: an alarm straight out of STROBE, or the
  // final outcome once the slave has fully released in RELEASE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    fin        = 1'b0;
    fin_status = ST_OK;
    if (state == S_STROBE && resp_idle && cnt == CNT_W'(ALARM_DLY_TICKS - 1)) begin
      fin        = 1'b1;
      fin_status = ST_ALARM;
    end else if (state == S_RELEASE && resp_idle) begin
      fin_status = result;
      case (result)
        ST_OK:   fin = (ok_cnt == total);
        ST_PE:   fin = 1'b1;
        default: fin = (retry == RT_W'(RETRY_MAX));
      endcase
    end
  end

  always_ff @(posedge __clk or negedge clm_) begin
    // NOTE: the asynchronous clear drives every bus line high at once, so a
    // master clear mid-transfer releases the bus without waiting for a clock.
    if (!clm_) begin
      state     <= S_IDLE;
      result    <= ST_OK;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      status    <= 2'd0;
      words     <= '0;
      rd_valid  <= 1'b0;
      rd_dt     <= '0;
      wr_req    <= 1'b0;
      dr_       <= 1'b1;
      dw_       <= 1'b1;
      din_      <= 1'b1;
      dnb_      <= '1;
      dad_      <= '1;
      ddt_      <= '1;
      op        <= 2'd0;
      ad        <= '0;
      total     <= '0;
      ok_cnt    <= '0;
      cnt       <= '0;
      retry     <= '0;
      load_wr   <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      wr_req   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op        <= cmd_op;
            ad        <= cmd_ad;
            total     <= {(cmd_len == '0), cmd_len};
            ok_cnt    <= '0;
            cnt       <= '0;
            retry     <= '0;
            load_wr   <= 1'b0;
            dnb_      <= ~cmd_nb;
            dad_      <= ~cmd_ad;
            ddt_      <= cmd_op[0] ? ~cmd_dt : '1;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (load_wr) begin
            load_wr <= 1'b0;
            ddt_    <= ~wr_dt;
          end
          if (cnt == CNT_W'(SETTLE_TICKS - 1)) begin
            cnt   <= '0;
            state <= S_STROBE;
            case (op)
              2'd0:    dr_  <= 1'b0;
              2'd1:    dw_  <= 1'b0;
              default: din_ <= 1'b0;
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STROBE: begin
          if (!rpe_s) begin
            result <= ST_PE;
            state  <= S_RELEASE;
          end else if (!rok_s) begin
            result <= ST_OK;
            ok_cnt <= ok_cnt + 1'b1;
            if (!op[0]) begin
              rd_valid <= 1'b1;
              rd_dt    <= ~rdt_;
            end
            state <= S_RELEASE;
          end else if (!ren_s) begin
            result <= ST_EN;
            state  <= S_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (!rpe_s || !rok_s || !ren_s) begin
            dr_  <= 1'b1;
            dw_  <= 1'b1;
            din_ <= 1'b1;
          end
        end

        S_RELEASE: begin
          if (resp_idle && !fin) begin
            if (result == ST_OK) begin
              wr_req <= op[0];
              state  <= S_NEXT;
            end else begin
              retry <= retry + 1'b1;
              cnt   <= '0;
              state <= S_SETUP;
            end
          end
        end

        S_NEXT: begin
          ad      <= ad + AW'(1);
          dad_    <= ~(ad + AW'(1));
          retry   <= '0;
          cnt     <= '0;
          load_wr <= op[0];
          state   <= S_SETUP;
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // NOTE: these assignments come after the case on purpose; the last
      // non-blocking assignment to a register wins, so completion overrides
      // whatever the state branch scheduled.
      if (fin) begin
        done   <= 1'b1;
        status <= fin_status;
        words  <= ok_cnt;
        dr_    <= 1'b1;
        dw_    <= 1'b1;
        din_   <= 1'b1;
        dnb_   <= '1;
        dad_   <= '1;
        ddt_   <= '1;
        state  <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: scripted/random slave responses checked
// against a transaction-level model of the expected strobes and outcome.
module tb_bus_master;
  localparam int AW              = 16;
  localparam int DW              = 16;
  localparam int LEN_W           = 4;
  localparam int SETTLE_TICKS    = 3;
  localparam int ALARM_DLY_TICKS = 250;
  localparam int RETRY_MAX       = 3;

  typedef enum int {R_OK, R_EN, R_PE, R_NONE, R_PEOK} resp_e;
  typedef struct {
    int            kind;
    logic [3:0]    nb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } strobe_t;

  logic             __clk = 1'b0;
  logic             clm_  = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [3:0]       cmd_nb = '0;
  logic [AW-1:0]    cmd_ad = '0;
  logic [DW-1:0]    cmd_dt = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wr_req;
  logic [DW-1:0]    wr_dt = '0;
  logic             rd_valid;
  logic [DW-1:0]    rd_dt;
  logic             done;
  logic [1:0]       status;
  logic [LEN_W:0]   words;
  logic             dr_, dw_, din_;
  logic [3:0]       dnb_;
  logic [AW-1:0]    dad_;
  logic [DW-1:0]    ddt_;
  logic             rok_, ren_, rpe_;
  logic [DW-1:0]    rdt_;

  bus_master #(
    .AW(AW), .DW(DW), .LEN_W(LEN_W), .SETTLE_TICKS(SETTLE_TICKS),
    .ALARM_DLY_TICKS(ALARM_DLY_TICKS), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .__clk(__clk), .clm_(clm_),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_nb(cmd_nb),
    .cmd_ad(cmd_ad), .cmd_dt(cmd_dt), .cmd_len(cmd_len),
    .wr_req(wr_req), .wr_dt(wr_dt), .rd_valid(rd_valid), .rd_dt(rd_dt),
    .done(done), .status(status), .words(words),
    .dr_(dr_), .dw_(dw_), .din_(din_), .dnb_(dnb_), .dad_(dad_), .ddt_(ddt_),
    .rok_(rok_), .ren_(ren_), .rpe_(rpe_), .rdt_(rdt_)
  );

  always #5 __clk = ~__clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus shared with the slave and monitor (written by the main process only).
  resp_e         script[$];
  int            script_base = 0;
  int            script_epoch = 0;
  int            slave_dly = 0;
  logic [DW-1:0] rd_seed = '0;
  logic [DW-1:0] wdata[$];
  int            wr_base = 0;
  resp_e         cur_script[$];

  // Observations (written by the monitor only).
  strobe_t       strobe_log[$];
  logic [DW-1:0] rd_log[$];
  int            wr_req_cnt = 0;
  int            done_cnt = 0;
  logic [1:0]    done_status = '0;
  logic [LEN_W:0] done_words = '0;
  logic          bus_idle_at_done = 1'b0;
  int            low_len = 0;
  int            last_low_len = 0;
  logic          prev_low = 1'b0;

  // Expectations (written by the main process only).
  strobe_t       exp_strobes[$];
  logic [DW-1:0] exp_rd[$];

  wire any_low = !(dr_ && dw_ && din_);

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return a ^ rd_seed;
  endfunction

  always @(negedge __clk) begin : monitor
    strobe_t s;
    int idx;
    if (rd_valid) rd_log.push_back(rd_dt);
    if (wr_req) begin
      wr_req_cnt++;
      idx = wr_req_cnt - wr_base;
      if (idx < wdata.size()) wr_dt = wdata[idx];
    end
    if (done) begin
      done_cnt++;
      done_status = status;
      done_words  = words;
      bus_idle_at_done = dr_ && dw_ && din_ && (&dad_) && (&ddt_) && (&dnb_);
    end
    if (any_low) begin
      if (!prev_low) begin
        s.kind = !dr_ ? 0 : (!dw_ ? 1 : 2);
        s.nb   = ~dnb_;
        s.addr = ~dad_;
        s.data = ~ddt_;
        strobe_log.push_back(s);
        low_len = 0;
      end
      low_len++;
    end else if (prev_low) begin
      last_low_len = low_len;
    end
    prev_low = any_low;
  end

  // Bus slave: one scripted response per strobe, held until the strobe rises.
  initial begin : slave
    int ptr;
    int epoch;
    int n;
    resp_e r;
    ptr = 0;
    epoch = 0;
    rok_ = 1'b1; ren_ = 1'b1; rpe_ = 1'b1; rdt_ = '1;
    forever begin
      @(negedge __clk);
      if (any_low) begin
        if (epoch != script_epoch) begin
          epoch = script_epoch;
          ptr = script_base;
        end
        r = (ptr < script.size()) ? script[ptr] : R_OK;
        ptr++;
        n = 0;
        while (n < slave_dly && any_low) begin
          @(negedge __clk);
          n++;
        end
        if (any_low) begin
          case (r)
            R_OK:   begin rok_ = 1'b0; rdt_ = ~slave_data(~dad_); end
            R_EN:   ren_ = 1'b0;
            R_PE:   rpe_ = 1'b0;
            R_PEOK: begin rok_ = 1'b0; rpe_ = 1'b0; rdt_ = ~slave_data(~dad_); end
            default: ;
          endcase
        end
        n = 0;
        while (any_low && n < 2000) begin
          @(negedge __clk);
          n++;
        end
        rok_ = 1'b1; ren_ = 1'b1; rpe_ = 1'b1; rdt_ = '1;
      end
    end
  end

  task automatic fill_wdata(input int total);
    wdata.delete();
    for (int i = 0; i < total; i++) wdata.push_back(DW'($urandom));
  endtask

  // Transaction-level model: walk words and attempts through the script.
  task automatic build_expect(input logic [1:0] op, input logic [3:0] nb, input logic [AW-1:0] ad,
                              input int total, output int est, output int ewords, output int ewr);
    int p;
    int att;
    bit stop;
    resp_e r;
    strobe_t s;
    exp_strobes.delete();
    exp_rd.delete();
    est = 0; ewords = 0; ewr = 0; p = 0; stop = 0;
    for (int w = 0; w < total && !stop; w++) begin
      att = 0;
      while (1) begin
        r = (p < cur_script.size()) ? cur_script[p] : R_OK;
        p++;
        s.kind = (op == 2'd0) ? 0 : ((op == 2'd1) ? 1 : 2);
        s.nb   = nb;
        s.addr = ad + AW'(w);
        s.data = op[0] ? wdata[w] : '0;
        exp_strobes.push_back(s);
        if (r == R_PE || r == R_PEOK) begin est = 2; stop = 1; break; end
        if (r == R_NONE) begin est = 3; stop = 1; break; end
        if (r == R_OK) begin
          ewords++;
          if (!op[0]) exp_rd.push_back(slave_data(s.addr));
          if (op[0] && w < total - 1) ewr++;
          break;
        end
        att++;
        if (att > RETRY_MAX) begin est = 1; stop = 1; break; end
      end
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [3:0] nb, input logic [AW-1:0] ad,
                           input logic [LEN_W-1:0] len, input int dly);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge __clk); n++; end
    script_base = script.size();
    foreach (cur_script[i]) script.push_back(cur_script[i]);
    script_epoch++;
    slave_dly = dly;
    wr_base = wr_req_cnt;
    wr_dt = '0;
    cmd_op = op; cmd_nb = nb; cmd_ad = ad; cmd_len = len; cmd_dt = wdata[0];
    cmd_valid = 1'b1;
    @(negedge __clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] nb,
                         input logic [AW-1:0] ad, input logic [LEN_W-1:0] len, input int dly);
    int total, est, ewords, ewr, s0, r0, w0, d0, n, ns, nr;
    total = (len == '0) ? (1 << LEN_W) : int'(len);
    build_expect(op, nb, ad, total, est, ewords, ewr);
    s0 = strobe_log.size(); r0 = rd_log.size(); w0 = wr_req_cnt; d0 = done_cnt;
    start_cmd(op, nb, ad, len, dly);
    n = 0;
    while (done_cnt == d0 && n < 6000) begin @(negedge __clk); n++; end
    @(negedge __clk);
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL %s done_pulses got %0d want 1", name, done_cnt - d0);
    end
    vectors++;
    if (done_status !== 2'(est)) begin
      miscompares++;
      $display("FAIL %s status got %0d want %0d", name, done_status, est);
    end
    vectors++;
    if (done_words !== (LEN_W+1)'(ewords)) begin
      miscompares++;
      $display("FAIL %s words got %0d want %0d", name, done_words, ewords);
    end
    vectors++;
    if (!bus_idle_at_done) begin
      miscompares++;
      $display("FAIL %s bus_released_at_done got 0 want 1", name);
    end
    ns = strobe_log.size() - s0;
    vectors++;
    if (ns != exp_strobes.size()) begin
      miscompares++;
      $display("FAIL %s strobe_count got %0d want %0d", name, ns, exp_strobes.size());
    end
    for (int i = 0; i < ns && i < exp_strobes.size(); i++) begin
      vectors++;
      if (strobe_log[s0+i].kind != exp_strobes[i].kind || strobe_log[s0+i].nb !== exp_strobes[i].nb ||
          strobe_log[s0+i].addr !== exp_strobes[i].addr || strobe_log[s0+i].data !== exp_strobes[i].data) begin
        miscompares++;
        $display("FAIL %s strobe[%0d] got kind=%0d nb=%h ad=%h dt=%h want kind=%0d nb=%h ad=%h dt=%h",
                 name, i, strobe_log[s0+i].kind, strobe_log[s0+i].nb, strobe_log[s0+i].addr,
                 strobe_log[s0+i].data, exp_strobes[i].kind, exp_strobes[i].nb,
                 exp_strobes[i].addr, exp_strobes[i].data);
      end
    end
    nr = rd_log.size() - r0;
    vectors++;
    if (nr != exp_rd.size()) begin
      miscompares++;
      $display("FAIL %s rd_valid_count got %0d want %0d", name, nr, exp_rd.size());
    end
    for (int i = 0; i < nr && i < exp_rd.size(); i++) begin
      vectors++;
      if (rd_log[r0+i] !== exp_rd[i]) begin
        miscompares++;
        $display("FAIL %s rd_dt[%0d] got %h want %h", name, i, rd_log[r0+i], exp_rd[i]);
      end
    end
    vectors++;
    if (wr_req_cnt - w0 != ewr) begin
      miscompares++;
      $display("FAIL %s wr_req_count got %0d want %0d", name, wr_req_cnt - w0, ewr);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0 || wr_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy=%b done=%b rdv=%b wrq=%b want 1 0 0 0", cmd_ready, done, rd_valid, wr_req);
    end
    vectors++;
    if (status !== 2'd0 || words !== '0 || rd_dt !== '0) begin
      miscompares++;
      $display("FAIL reset_results got st=%0d words=%0d rd_dt=%h want 0 0 0000", status, words, rd_dt);
    end
    vectors++;
    if ({dr_, dw_, din_, dnb_, dad_, ddt_} !== '1) begin
      miscompares++;
      $display("FAIL reset_bus got %b%b%b %h %h %h want all ones", dr_, dw_, din_, dnb_, dad_, ddt_);
    end
    @(negedge __clk);
    clm_ = 1'b1;
    repeat (3) @(negedge __clk);
    vectors++;
    if (cmd_ready !== 1'b1 || {dr_, dw_, din_, dad_} !== '1) begin
      miscompares++;
      $display("FAIL reset_idle got rdy=%b strobes=%b%b%b dad_=%h want idle", cmd_ready, dr_, dw_, din_, dad_);
    end
  endtask

  task automatic test_single_read();
    int r0;
    cur_script = '{R_OK};
    rd_seed = 16'h1234 ^ 16'h0100;
    fill_wdata(1);
    r0 = rd_log.size();
    run_cmd("single_read", 2'd0, 4'd2, 16'h0100, 4'd1, 8);
    vectors++;
    if (rd_log.size() <= r0 || rd_log[r0] !== 16'h1234) begin
      miscompares++;
      $display("FAIL single_read_value got %h want 1234", (rd_log.size() > r0) ? rd_log[r0] : 16'hxxxx);
    end
  endtask

  task automatic test_write_burst();
    cur_script = '{R_OK, R_OK, R_OK};
    fill_wdata(3);
    run_cmd("write_burst", 2'd1, 4'd5, 16'hFFFF, 4'd3, 2);
  endtask

  task automatic test_retry();
    cur_script = '{R_EN, R_EN, R_OK};
    fill_wdata(1);
    run_cmd("retry_ok", 2'd0, 4'd1, 16'h2000, 4'd1, 1);
    cur_script = '{R_EN, R_EN, R_EN, R_EN, R_EN};
    fill_wdata(1);
    run_cmd("retry_exhaust", 2'd3, 4'd1, 16'h2001, 4'd1, 0);
  endtask

  task automatic test_alarm();
    cur_script = '{R_NONE};
    fill_wdata(1);
    run_cmd("alarm_single", 2'd0, 4'd3, 16'h3000, 4'd1, 0);
    vectors++;
    if (last_low_len != ALARM_DLY_TICKS) begin
      miscompares++;
      $display("FAIL alarm_strobe_len got %0d want %0d", last_low_len, ALARM_DLY_TICKS);
    end
    cur_script = '{R_OK, R_NONE};
    fill_wdata(4);
    run_cmd("alarm_burst", 2'd0, 4'd3, 16'h3100, 4'd4, 1);
  endtask

  task automatic test_priority();
    cur_script = '{R_PEOK};
    fill_wdata(1);
    run_cmd("parity_priority", 2'd2, 4'd7, 16'h4000, 4'd1, 0);
  endtask

  task automatic test_reset_mid();
    int d0, n;
    cur_script = '{R_NONE};
    fill_wdata(1);
    d0 = done_cnt;
    start_cmd(2'd1, 4'd9, 16'h5000, 4'd1, 0);
    n = 0;
    while (!any_low && n < 50) begin @(negedge __clk); n++; end
    repeat (5) @(negedge __clk);
    #2 clm_ = 1'b0;
    #1;
    vectors++;
    if ({dr_, dw_, din_, dnb_, dad_, ddt_} !== '1) begin
      miscompares++;
      $display("FAIL midreset_bus got %b%b%b %h %h %h want all ones", dr_, dw_, din_, dnb_, dad_, ddt_);
    end
    vectors++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl got rdy=%b done=%b want 1 0", cmd_ready, done);
    end
    repeat (3) @(negedge __clk);
    clm_ = 1'b1;
    repeat (4) @(negedge __clk);
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL midreset_no_done got %0d pulses want 0", done_cnt - d0);
    end
    cur_script = '{R_OK};
    fill_wdata(1);
    run_cmd("after_reset", 2'd1, 4'd9, 16'h5000, 4'd1, 1);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [LEN_W-1:0] len;
    logic [AW-1:0] ad;
    int total, pick;
    for (int k = 0; k < 25; k++) begin
      op  = 2'($urandom_range(0, 3));
      len = LEN_W'($urandom_range(0, 5));
      ad  = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFE) : AW'($urandom);
      total = (len == '0) ? (1 << LEN_W) : int'(len);
      rd_seed = DW'($urandom);
      cur_script.delete();
      for (int i = 0; i < total * (RETRY_MAX + 1); i++) begin
        pick = $urandom_range(0, 99);
        cur_script.push_back(pick < 65 ? R_OK : pick < 85 ? R_EN : pick < 93 ? R_PE :
                             pick < 96 ? R_PEOK : R_NONE);
      end
      fill_wdata(total);
      run_cmd($sformatf("random%0d", k), op, 4'($urandom), ad, len, $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_retry();
    test_alarm();
    test_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
